// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: initial AddRoundKey, NR datapath rounds, valid/ready handshake.
// Optional `define AES_CTRL_ABORT_EN adds a synchronous abort input.
module aes_round_ctrl #(
    parameter int ENC_DEC = 0,
    parameter int NR      = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] data_in,
    input  logic [0:127] round_key,
    output logic [3:0]   key_idx,
    output logic [0:127] round_in,
    input  logic [0:127] round_out,
    output logic         final_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] data_out
`ifdef AES_CTRL_ABORT_EN
    ,
    input  logic         abort
`endif
);

    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
        $error("aes_round_ctrl: NR must be 10, 12 or 14");
    end
    if (!(ENC_DEC == 0 || ENC_DEC == 1)) begin : g_bad_enc_dec
        $error("aes_round_ctrl: ENC_DEC must be 0 or 1");
    end

    localparam logic [3:0] NR_L      = 4'(NR);
    localparam logic [3:0] FIRST_KEY = (ENC_DEC != 0) ? NR_L : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_t;

    state_t       state, state_nx;
    logic [0:127] state_reg, state_reg_nx;
    logic [3:0]   rnd, rnd_nx;
    logic         abort_req;

`ifdef AES_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            state_reg <= '0;
            rnd       <= '0;
        end else begin
            state     <= state_nx;
            state_reg <= state_reg_nx;
            rnd       <= rnd_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        state_reg_nx = state_reg;
        rnd_nx       = rnd;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        final_round  = 1'b0;
        key_idx      = (ENC_DEC != 0) ? (NR_L - rnd) : rnd;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                key_idx  = FIRST_KEY;
                if (in_valid) begin
                    state_reg_nx = data_in ^ round_key;
                    rnd_nx       = 4'd1;
                    state_nx     = ROUND;
                end
            end
            ROUND: begin
                final_round  = (rnd == NR_L);
                state_reg_nx = round_out;
                if (final_round) begin
                    state_nx = DONE;
                end else begin
                    rnd_nx = rnd + 4'd1;
                end
                if (abort_req) begin
                    state_reg_nx = '0;
                    rnd_nx       = '0;
                    state_nx     = IDLE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (abort_req) begin
                    state_reg_nx = '0;
                    rnd_nx       = '0;
                    state_nx     = IDLE;
                end else if (out_ready) begin
                    rnd_nx   = '0;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign round_in = state_reg;
    assign data_out = state_reg;

endmodule
